// File: rtl/mac_array_gen_if.sv
// -----------------------------------------------------------------------------
// mac_array_gen_if
//   Bundles the feeder/array/FIFO-facing signals of the MAC array.
//
//   en        : 1 = array advances, 0 = every register holds (stall)
//   mode      : 0 = unsigned multiply/accumulate, 1 = signed
//   data_mode : 1 = broadcast inst_w to all rows, 0 = skew one cycle per row
//   inst_w    : 00 idle, 01 kernel load, 10 execute, 11 flush
//   in_w      : per-row {zero_flag, data} slices, row r at [(bw+1)(r+1)-1:(bw+1)r]
//   in_n      : north partial sums, column c at slice c
//   out_s     : south partial sums from the last row
//   valid     : per-column result-valid
//
//   master = feeder/testbench side, slave = array side.
// -----------------------------------------------------------------------------
interface mac_array_gen_if #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int row     = 8
);
  logic                     en;
  logic                     mode;
  logic                     data_mode;
  logic [1:0]               inst_w;
  logic [row*(bw+1)-1:0]    in_w;
  logic [psum_bw*col-1:0]   in_n;
  logic [psum_bw*col-1:0]   out_s;
  logic [col-1:0]           valid;

  modport master (
    output en, mode, data_mode, inst_w, in_w, in_n,
    input  out_s, valid
  );

  modport slave (
    input  en, mode, data_mode, inst_w, in_w, in_n,
    output out_s, valid
  );
endinterface

// File: rtl/mac_array_gen.sv
// -----------------------------------------------------------------------------
// mac_array_gen
//   Parametrised weight-stationary systolic MAC array of row x col PEs.
//   Instructions enter through a per-row skew chain (or are broadcast), ride
//   east through each row alongside the activation, and partial sums flow
//   south from in_n to out_s. Supports signed/unsigned multiply, optional
//   saturating accumulation, zero-skip gating, global stall and a flush
//   instruction that unloads the stationary kernels.
//
//   Parameters : bw (data width), psum_bw (partial-sum width, >= 2*bw),
//                col, row (array size), SAT (1 = saturating accumulate)
//   clk        : single clock, rising edge
//   reset      : synchronous, active-low; clears all state regardless of en
//   bus        : mac_array_gen_if slave modport (en, mode, data_mode, inst_w,
//                in_w, in_n in; out_s, valid out)
// -----------------------------------------------------------------------------
module mac_array_gen #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int row     = 8,
  parameter int SAT     = 0
) (
  input  logic           clk,
  input  logic           reset,
  mac_array_gen_if.slave bus
);

  typedef enum logic [1:0] {
    INST_IDLE  = 2'b00,
    INST_LOAD  = 2'b01,
    INST_EXEC  = 2'b10,
    INST_FLUSH = 2'b11
  } inst_e;

  logic [1:0]         isk_q   [row];
  logic [bw-1:0]      a_w     [row][col];
  logic               z_w     [row][col];
  logic [1:0]         inst_fw [row][col];
  logic [psum_bw-1:0] psum_w  [row][col];
  logic               valid_w [row][col];

  // Instruction skew chain: row r sees inst_w r+1 enabled cycles after it
  // was sampled, or one cycle after in broadcast mode.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < row; i++) begin
        isk_q[i] <= INST_IDLE;
      end
    end else if (bus.en) begin
      isk_q[0] <= bus.inst_w;
      for (int i = 1; i < row; i++) begin
        isk_q[i] <= bus.data_mode ? bus.inst_w : isk_q[i-1];
      end
    end
  end

  for (genvar gr = 0; gr < row; gr++) begin : g_row
    for (genvar gc = 0; gc < col; gc++) begin : g_pe
      logic [bw-1:0]      a_in;
      logic               z_in;
      logic [1:0]         inst_in;
      logic [psum_bw-1:0] psum_in;

      logic [bw-1:0]      a_q;
      logic               z_q;
      logic [bw-1:0]      w_q;
      logic               loaded_q;
      logic [1:0]         inst_q;
      logic [psum_bw-1:0] psum_q;
      logic               valid_q;

      logic [2*bw-1:0]    a_ext;
      logic [2*bw-1:0]    w_ext;
      logic [2*bw-1:0]    prod;
      logic [psum_bw:0]   sum;
      logic [psum_bw-1:0] psum_d;

      // Column 0 takes data straight off the west bus and its instruction
      // from the skew chain; later columns take everything from the west PE.
      if (gc == 0) begin : g_west
        assign a_in    = bus.in_w[(bw+1)*gr +: bw];
        assign z_in    = bus.in_w[(bw+1)*gr + bw];
        assign inst_in = isk_q[gr];
      end else begin : g_chain
        assign a_in    = a_w[gr][gc-1];
        assign z_in    = z_w[gr][gc-1];
        assign inst_in = inst_fw[gr][gc-1];
      end

      if (gr == 0) begin : g_north
        assign psum_in = bus.in_n[psum_bw*gc +: psum_bw];
      end else begin : g_south
        assign psum_in = psum_w[gr-1][gc];
      end

      // Operands are extended to 2*bw before multiplying so one unsigned
      // multiplier yields the correct low 2*bw product bits in both modes.
      // A set zero flag forces both operands to zero so nothing toggles.
      // The sum is formed one bit wider than psum_bw so overflow is visible.
      always_comb begin
        a_ext  = '0;
        w_ext  = '0;
        prod   = '0;
        sum    = '0;
        psum_d = '0;
        if (!z_in) begin
          a_ext = {{bw{bus.mode & a_in[bw-1]}}, a_in};
          w_ext = {{bw{bus.mode & w_q[bw-1]}}, w_q};
        end
        prod   = a_ext * w_ext;
        sum    = {bus.mode & psum_in[psum_bw-1], psum_in}
               + {{(psum_bw+1-2*bw){bus.mode & prod[2*bw-1]}}, prod};
        psum_d = sum[psum_bw-1:0];
        if (SAT != 0) begin
          if (bus.mode) begin
            // Signed overflow shows as the two top bits of the wide sum disagreeing.
            if (sum[psum_bw] != sum[psum_bw-1]) begin
              psum_d = sum[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}}
                                    : {1'b0, {(psum_bw-1){1'b1}}};
            end
          end else if (sum[psum_bw]) begin
            psum_d = '1;
          end
        end
        if (z_in) begin
          psum_d = psum_in;
        end
      end

      // A load consumed by this PE is forwarded as idle, so the k-th weight
      // of a burst settles in column k. Flush passes through untouched.
      always_ff @(posedge clk) begin
        if (!reset) begin
          a_q      <= '0;
          z_q      <= 1'b0;
          w_q      <= '0;
          loaded_q <= 1'b0;
          inst_q   <= INST_IDLE;
          psum_q   <= '0;
          valid_q  <= 1'b0;
        end else if (bus.en) begin
          if (inst_in != INST_IDLE) begin
            a_q <= a_in;
            z_q <= z_in;
          end
          if (inst_in == INST_FLUSH) begin
            inst_q <= INST_FLUSH;
          end else begin
            inst_q <= {inst_in[1], inst_in[0] & loaded_q};
          end
          case (inst_in)
            INST_LOAD: begin
              valid_q <= 1'b0;
              if (!loaded_q) begin
                w_q      <= a_in;
                loaded_q <= 1'b1;
              end
            end
            INST_EXEC: begin
              valid_q <= 1'b1;
              psum_q  <= psum_d;
            end
            INST_FLUSH: begin
              loaded_q <= 1'b0;
              w_q      <= '0;
              psum_q   <= '0;
              valid_q  <= 1'b0;
            end
            default: begin
              valid_q <= 1'b0;
            end
          endcase
        end
      end

      assign a_w[gr][gc]     = a_q;
      assign z_w[gr][gc]     = z_q;
      assign inst_fw[gr][gc] = inst_q;
      assign psum_w[gr][gc]  = psum_q;
      assign valid_w[gr][gc] = valid_q;
    end
  end

  for (genvar gc = 0; gc < col; gc++) begin : g_out
    assign bus.out_s[psum_bw*gc +: psum_bw] = psum_w[row-1][gc];
    assign bus.valid[gc]                    = valid_w[row-1][gc];
  end

endmodule
